mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates a single-ported, pipelined main memory between the instruction-fetch miss path (I-side) and the data-memory path (D-side) of the 5-stage pipeline.
- I-side and D-side reads are cache-line burst fills of BURST_LEN words.
- D-side writes are single-word write-through.
- Sequences the memory address stream, counts returned words and signals completion; the pipeline stalls on outstanding requests.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width
BURST_LEN, 8, words per line fill (power of 2, >=2)
MEM_LAT, 4, cycles from mem_en (read) to matching mem_rvld (>=1, fixed, in-order)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  I-side fill request; held with i_addr until i_done
i_addr  in  ADDR_W  I-side miss address, any alignment
i_grant  out  1  one-cycle pulse: I fill started
i_data_vld  out  1  I fill word valid
i_data  out  DATA_W  I fill word
i_word_idx  out  log2(BURST_LEN)  index of i_data within line
i_done  out  1  one-cycle pulse with last I word
d_req  in  1  D-side request; held with d_wr/d_addr/d_wdata until d_done
d_wr  in  1  1=single-word write, 0=line fill
d_addr  in  ADDR_W  D-side address
d_wdata  in  DATA_W  D-side write data
d_grant, d_data_vld, d_data, d_word_idx, d_done  out  as I-side  D-side equivalents
mem_en  out  1  memory command valid
mem_wr  out  1  command is write
mem_addr  out  ADDR_W  command address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data
mem_rvld  in  1  read data valid
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, counters 0, RR pointer = I; all outputs 0.
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- IDLE arbitration, evaluated at cycle T:
  - d_req with d_wr=1 -> D_WRITE.
  - d_req with d_wr=0 -> D_FILL.
  - i_req only -> I_FILL.
  - Both requests -> D wins.
- Entering any state at T+1: x_grant pulses in T+1. mem_en, mem_wr, mem_addr and mem_wdata are registered outputs.
- Fill, issue phase:
  - base = addr with low log2(BURST_LEN)+1 bits cleared.
  - Cycles T+1..T+BURST_LEN: mem_en=1, mem_wr=0, mem_addr = base + 2*k, k=0..BURST_LEN-1, one per cycle, no gaps.
  - 16-bit address wraps modulo 2^ADDR_W.
- Fill, return phase:
  - x_data_vld = mem_rvld and state matches side; x_data = mem_rdata; x_word_idx = return counter (combinational pass-through).
  - Return counter increments per mem_rvld.
  - x_done pulses with word BURST_LEN-1, i.e. at T+MEM_LAT+BURST_LEN; state becomes IDLE the next cycle.
- D_WRITE, single cycle T+1: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata; d_grant and d_done both pulse. IDLE at T+2.
- Minimum one IDLE cycle between transactions; no back-to-back grant.
- Requests arriving while busy wait; they are not queued beyond the held req level.
- mem_rvld outside a fill state is ignored: no data_vld, no counter change.
- Extra mem_rvld after the return count completes is ignored.
- mem_rdata is never forwarded to the non-granted side.
- Reset mid-transaction aborts immediately to IDLE; no done pulse.

Optional Feature:
MEM_ARB_RR_EN
- Defined: on simultaneous i_req and d_req in IDLE, grant the side not served last. Pointer updates on every grant. D writes count as D service.
- Undefined: fixed D priority; pointer logic absent.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (2-bit IDLE=0, I_FILL=1, D_FILL=2, D_WRITE=3)
  - side encoding (SIDE_I=0, SIDE_D=1)
  - IDX_W = log2(BURST_LEN)
  - line-offset mask constant
- Sub-module mem_burst_seq: issue counter, return counter, base/offset address generation, last-issue and last-return flags. Instantiated once and shared by both fill states.

Test Plan:
- Reset then i_req=1, i_addr=0x1236 at T -> i_grant T+1; mem_addr 0x1230,0x1232..0x123E over T+1..T+8; with memory returning addr+0x100, i_data 0x1330.. with idx 0..7 at T+5..T+12; i_done at T+12; busy=0 at T+13.
- d_req=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> T+1: mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_grant=d_done=1; IDLE at T+2.
- i_req and d_req (fill, 0x2000) same cycle, fixed priority -> D_FILL first; I granted 2 cycles after d_done. With MEM_ARB_RR_EN and last served=D -> I granted first.
- Fill at 0xFFF8 -> addresses 0xFFF0..0xFFFE, no overflow past 0xFFFE; stray mem_rvld while IDLE -> no i/d_data_vld.
- rst_n low at T+6 of I fill -> all outputs 0 asynchronously, no i_done; after release with i_req still high -> fresh grant, addresses restart at base.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and line geometry for the I/D main-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 8;
  localparam int MEM_LAT_DEF   = 4;

  localparam int IDX_W = $clog2(BURST_LEN_DEF);
  // Byte offset within a line of 16-bit words.
  localparam int LINE_MASK = 2 * BURST_LEN_DEF - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

endpackage

// File: rtl/mem_arbiter_seq.sv
// Line-fill sequencer shared by the I and D fill states: issues the
// line's word addresses back to back and counts the returning words.
module mem_burst_seq
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rvld_i,
  output logic [ADDR_W-1:0] base_o,
  output logic              iss_vld_o,
  output logic [ADDR_W-1:0] iss_addr_o,
  output logic [IDX_W-1:0]  ret_idx_o,
  output logic              last_ret_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  iss_cnt_q, iss_cnt_d;
  logic [IDX_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              iss_act_q, iss_act_d;

  assign base_o     = addr_i & ~ADDR_W'(LINE_MASK);
  assign iss_vld_o  = iss_act_q;
  assign iss_addr_o = base_q + ADDR_W'({iss_cnt_q, 1'b0});
  assign ret_idx_o  = ret_cnt_q;
  assign last_ret_o = (ret_cnt_q == IDX_W'(BURST_LEN - 1));

  // Word 0 leaves with the grant, so the issue counter resumes at 1.
  always_comb begin
    base_d    = base_q;
    iss_cnt_d = iss_cnt_q;
    iss_act_d = iss_act_q;
    ret_cnt_d = ret_cnt_q;
    if (start_i) begin
      base_d    = base_o;
      iss_cnt_d = IDX_W'(1);
      iss_act_d = 1'b1;
      ret_cnt_d = '0;
    end else begin
      if (iss_act_q) begin
        iss_cnt_d = iss_cnt_q + IDX_W'(1);
        if (iss_cnt_q == IDX_W'(BURST_LEN - 1)) iss_act_d = 1'b0;
      end
      if (rvld_i) ret_cnt_d = ret_cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt_q <= '0;
      iss_act_q <= 1'b0;
      ret_cnt_q <= '0;
    end else begin
      iss_cnt_q <= iss_cnt_d;
      iss_act_q <= iss_act_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between I-side line fills and
// D-side fills/writes. Define MEM_ARB_RR_EN for round-robin on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_vld,
  output logic [DATA_W-1:0] i_data,
  output logic [IDX_W-1:0]  i_word_idx,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_vld,
  output logic [DATA_W-1:0] d_data,
  output logic [IDX_W-1:0]  d_word_idx,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvld,
  output logic              busy
);

  if (MEM_LAT < 1 || BURST_LEN < 2 || (1 << IDX_W) != BURST_LEN) begin : g_cfg_err
    $error("mem_arbiter: unsupported MEM_LAT/BURST_LEN");
  end

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              pick_d, prefer_i, start;
  logic              in_i_fill, in_d_fill, fill_rvld;
  logic [ADDR_W-1:0] seq_base, iss_addr;
  logic              iss_vld, last_ret;
  logic [IDX_W-1:0]  ret_idx;

`ifdef MEM_ARB_RR_EN
  side_e last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (d_req || i_req)) last_d = pick_d ? SIDE_D : SIDE_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SIDE_I;
    else        last_q <= last_d;
  end

  assign prefer_i = (last_q == SIDE_D);
`else
  assign prefer_i = 1'b0;
`endif

  assign pick_d    = d_req && !(i_req && prefer_i);
  assign in_i_fill = (state_q == I_FILL);
  assign in_d_fill = (state_q == D_FILL);
  assign fill_rvld = mem_rvld && (in_i_fill || in_d_fill);

  mem_burst_seq #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .addr_i     (pick_d ? d_addr : i_addr),
    .rvld_i     (fill_rvld),
    .base_o     (seq_base),
    .iss_vld_o  (iss_vld),
    .iss_addr_o (iss_addr),
    .ret_idx_o  (ret_idx),
    .last_ret_o (last_ret)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = 1'b0;
    start       = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          grant_d  = 1'b1;
          mem_en_d = 1'b1;
          if (d_wr) begin
            state_d     = D_WRITE;
            mem_wr_d    = 1'b1;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d    = D_FILL;
            start      = 1'b1;
            mem_addr_d = seq_base;
          end
        end else if (i_req) begin
          grant_d    = 1'b1;
          mem_en_d   = 1'b1;
          state_d    = I_FILL;
          start      = 1'b1;
          mem_addr_d = seq_base;
        end
      end
      I_FILL, D_FILL: begin
        if (iss_vld) begin
          mem_en_d   = 1'b1;
          mem_addr_d = iss_addr;
        end
        if (fill_rvld && last_ret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

  // Read data only reaches the side that owns the current fill.
  assign i_grant    = grant_q && in_i_fill;
  assign i_data_vld = mem_rvld && in_i_fill;
  assign i_data     = i_data_vld ? mem_rdata : '0;
  assign i_word_idx = in_i_fill ? ret_idx : '0;
  assign i_done     = i_data_vld && last_ret;

  assign d_grant    = grant_q && (in_d_fill || state_q == D_WRITE);
  assign d_data_vld = mem_rvld && in_d_fill;
  assign d_data     = d_data_vld ? mem_rdata : '0;
  assign d_word_idx = in_d_fill ? ret_idx : '0;
  assign d_done     = (d_data_vld && last_ret) || (state_q == D_WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory returning addr+0x100.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        stray = 1'b0;

  logic        i_grant, i_data_vld, i_done;
  logic [15:0] i_data;
  logic [2:0]  i_word_idx;
  logic        d_grant, d_data_vld, d_done;
  logic [15:0] d_data;
  logic [2:0]  d_word_idx;
  logic        mem_en, mem_wr, mem_rvld, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [LAT-1:0] pipe_v = '0;
  logic [15:0]    pipe_a [LAT];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_grant    (i_grant),
    .i_data_vld (i_data_vld),
    .i_data     (i_data),
    .i_word_idx (i_word_idx),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_grant    (d_grant),
    .d_data_vld (d_data_vld),
    .d_data     (d_data),
    .d_word_idx (d_word_idx),
    .d_done     (d_done),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvld   (mem_rvld),
    .busy       (busy)
  );

  always_ff @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], mem_en && !mem_wr};
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign mem_rvld  = pipe_v[LAT-1] | stray;
  assign mem_rdata = pipe_v[LAT-1] ? pipe_a[LAT-1] + 16'h0100 : 16'hDEAD;

  // Request already driven in cycle T; steps through T+1..T+13.
  task automatic fill_check(input bit dside, input logic [15:0] base);
    logic        grant, vld, done, other_vld;
    logic [15:0] data;
    logic [2:0]  idx;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      grant     = dside ? d_grant    : i_grant;
      vld       = dside ? d_data_vld : i_data_vld;
      done      = dside ? d_done     : i_done;
      data      = dside ? d_data     : i_data;
      idx       = dside ? d_word_idx : i_word_idx;
      other_vld = dside ? i_data_vld : d_data_vld;
      checks++;
      if (grant !== (k == 1)) begin
        errors++; $error("FAIL fill_grant k=%0d observed=%0h", k, grant);
      end
      checks++;
      if (mem_en !== (k <= 8)) begin
        errors++; $error("FAIL fill_mem_en k=%0d observed=%0h", k, mem_en);
      end
      if (k <= 8) begin
        checks++;
        if (mem_wr !== 1'b0) begin
          errors++; $error("FAIL fill_mem_wr k=%0d observed=%0h", k, mem_wr);
        end
        checks++;
        if (mem_addr !== base + 16'(2 * (k - 1))) begin
          errors++; $error("FAIL fill_mem_addr k=%0d observed=%0h", k, mem_addr);
        end
      end
      checks++;
      if (vld !== (k >= 5 && k <= 12)) begin
        errors++; $error("FAIL fill_vld k=%0d observed=%0h", k, vld);
      end
      checks++;
      if (other_vld !== 1'b0) begin
        errors++; $error("FAIL fill_other_vld k=%0d observed=%0h", k, other_vld);
      end
      if (k >= 5 && k <= 12) begin
        checks++;
        if (data !== base + 16'h0100 + 16'(2 * (k - 5))) begin
          errors++; $error("FAIL fill_data k=%0d observed=%0h", k, data);
        end
        checks++;
        if (idx !== 3'(k - 5)) begin
          errors++; $error("FAIL fill_idx k=%0d observed=%0h", k, idx);
        end
      end
      checks++;
      if (done !== (k == 12)) begin
        errors++; $error("FAIL fill_done k=%0d observed=%0h", k, done);
      end
      checks++;
      if (busy !== (k <= 12)) begin
        errors++; $error("FAIL fill_busy k=%0d observed=%0h", k, busy);
      end
      if (k == 12) begin
        if (dside) d_req = 1'b0;
        else       i_req = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    checks++;
    if (mem_en !== 1'b0) begin errors++; $error("FAIL rst_mem_en observed=%0h", mem_en); end
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $error("FAIL rst_mem_addr observed=%0h", mem_addr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy observed=%0h", busy); end
    checks++;
    if ({i_grant, d_grant, i_done, d_done} !== 4'b0000) begin
      errors++; $error("FAIL rst_grants observed=%0h", {i_grant, d_grant, i_done, d_done});
    end
    rst_n = 1'b1;
    @(negedge clk);

    // I-side fill from an unaligned miss address
    i_req = 1'b1; i_addr = 16'h1236;
    fill_check(1'b0, 16'h1230);

    // D-side single-word write
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin errors++; $error("FAIL wr_mem_en observed=%0h", mem_en); end
    checks++;
    if (mem_wr !== 1'b1) begin errors++; $error("FAIL wr_mem_wr observed=%0h", mem_wr); end
    checks++;
    if (mem_addr !== 16'h0040) begin errors++; $error("FAIL wr_mem_addr observed=%0h", mem_addr); end
    checks++;
    if (mem_wdata !== 16'hBEEF) begin errors++; $error("FAIL wr_mem_wdata observed=%0h", mem_wdata); end
    checks++;
    if (d_grant !== 1'b1) begin errors++; $error("FAIL wr_d_grant observed=%0h", d_grant); end
    checks++;
    if (d_done !== 1'b1) begin errors++; $error("FAIL wr_d_done observed=%0h", d_done); end
    checks++;
    if (i_grant !== 1'b0) begin errors++; $error("FAIL wr_i_grant observed=%0h", i_grant); end
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $error("FAIL wr_idle_busy observed=%0h", busy); end
    checks++;
    if (mem_en !== 1'b0) begin errors++; $error("FAIL wr_idle_mem_en observed=%0h", mem_en); end
    checks++;
    if (d_done !== 1'b0) begin errors++; $error("FAIL wr_idle_d_done observed=%0h", d_done); end

    // Simultaneous requests; D was served last
    i_req = 1'b1; i_addr = 16'h1236;
    d_req = 1'b1; d_addr = 16'h2000;
`ifdef MEM_ARB_RR_EN
    fill_check(1'b0, 16'h1230);
    fill_check(1'b1, 16'h2000);
`else
    fill_check(1'b1, 16'h2000);
    fill_check(1'b0, 16'h1230);
`endif

    // Stray read-valid while idle
    stray = 1'b1;
    #1;
    checks++;
    if (i_data_vld !== 1'b0) begin errors++; $error("FAIL stray_i_vld observed=%0h", i_data_vld); end
    checks++;
    if (d_data_vld !== 1'b0) begin errors++; $error("FAIL stray_d_vld observed=%0h", d_data_vld); end
    checks++;
    if (i_data !== 16'h0000) begin errors++; $error("FAIL stray_i_data observed=%0h", i_data); end
    @(negedge clk);
    stray = 1'b0;

    // Fill at the top of the address space
    i_req = 1'b1; i_addr = 16'hFFF8;
    fill_check(1'b0, 16'hFFF0);

    // Reset in the middle of an I fill
    i_req = 1'b1; i_addr = 16'h3456;
    repeat (6) @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin errors++; $error("FAIL mid_mem_en observed=%0h", mem_en); end
    checks++;
    if (mem_addr !== 16'h345A) begin errors++; $error("FAIL mid_mem_addr observed=%0h", mem_addr); end
    checks++;
    if (i_data_vld !== 1'b1) begin errors++; $error("FAIL mid_i_vld observed=%0h", i_data_vld); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $error("FAIL arst_busy observed=%0h", busy); end
    checks++;
    if (mem_en !== 1'b0) begin errors++; $error("FAIL arst_mem_en observed=%0h", mem_en); end
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $error("FAIL arst_mem_addr observed=%0h", mem_addr); end
    checks++;
    if (i_data_vld !== 1'b0) begin errors++; $error("FAIL arst_i_vld observed=%0h", i_data_vld); end
    checks++;
    if (i_word_idx !== 3'd0) begin errors++; $error("FAIL arst_i_idx observed=%0h", i_word_idx); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({i_done, i_data_vld, i_grant} !== 3'b000) begin
        errors++; $error("FAIL arst_no_done observed=%0h", {i_done, i_data_vld, i_grant});
      end
    end
    rst_n = 1'b1;
    fill_check(1'b0, 16'h3450);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
